demux16_collect: RTL and testbench
==================================

# demux16_collect

Registered 1-to-16 demultiplexer/collector: the write-side counterpart of the team's 16:1 bit mux. It accepts single data bits through a valid/ready handshake and steers each bit into one of 16 positions of an assembly word, by explicit 4-bit select or by an auto-incrementing pointer. Completed words are handed to a one-entry output register with valid/ready, so the block sits between a serial bit source and a 16-bit parallel consumer.

## Interface
- `WIDTH`, 16: assembled word width; only 16 is supported.
- `SEL_W`, 4: select width, equal to log2(`WIDTH`).

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in`  in  1  data bit.
- `sel`  in  4  target position in addressed mode.
- `mode`  in  1  0 = addressed (`sel`), 1 = sequential (pointer).
- `commit`  in  1  force word completion together with the accepted bit.
- `in_valid`  in  1  `in`/`sel`/`mode`/`commit` valid.
- `in_ready`  out  1  collector can accept a bit.
- `out`  out  16  completed word.
- `out_mask`  out  16  positions written in `out`.
- `out_valid`  out  1  `out`/`out_mask` valid.
- `out_ready`  in  1  consumer takes the word.

## Operation
- Accept occurs when `in_valid & in_ready`. Transfer occurs when `out_valid & out_ready`.
- States:
  - FILL: `in_ready`=1.
  - FULL: the assembled word is waiting for the output slot; `in_ready`=0.
- Word mode is latched from `mode` on the first accept of a word, i.e. when the mask is 0. Changes to `mode` mid-word are ignored until the next word.
- Addressed write:
  - `asm[sel]` <= `in`; `mask[sel]` <= 1.
  - Rewriting a position overwrites the data bit; the mask is unchanged.
- Sequential write:
  - `asm[ptr]` <= `in`; `mask[ptr]` <= 1; `ptr` <= `ptr`+1.
  - `sel` is ignored.
- Completion happens on an accept when any of the following holds:
  - the updated mask is 16'hFFFF;
  - sequential mode and `ptr` is 15;
  - `commit` is 1.
- `commit` without an accept has no effect. Every completed word has at least one mask bit set.
- On completion with the slot free (`!out_valid` or a transfer this cycle):
  - `out`/`out_mask` load the updated `asm`/`mask`, and `out_valid` <= 1.
  - `asm`, `mask` and `ptr` clear to 0; state stays FILL.
- On completion with the slot occupied and no transfer this cycle:
  - the updated `asm`/`mask` are held; state goes to FULL.
- In FULL, when `!out_valid` or a transfer occurs: load `out` from `asm`, clear `asm`/`mask`/`ptr`, go to FILL.
- A transfer with no new word loading clears `out_valid`. `out` and `out_mask` keep their old values.
- Unwritten positions in a word read 0.

## Timing
- Reset values:
  - `out`=0, `out_mask`=0, `out_valid`=0.
  - `asm`=0, `mask`=0, `ptr`=0, state FILL, so `in_ready`=1 immediately after reset.
- Reset mid-word discards the partial word and any held output.
- Latency: the completing accept at edge N gives `out_valid`=1 after edge N.
- `in_ready` is combinational from state only (no dependency on `in_valid` or `out_ready`).
- Throughput: one bit per cycle. One full sequential word every 16 cycles with no bubble while `out_ready`=1.
- Backpressure: with the slot held, a second completed word waits in FULL. The cycle in which `out_ready` is seen high, that word moves to `out`. `in_ready` returns to 1 the following cycle.
- `out`/`out_mask` are stable while `out_valid`=1 and `out_ready`=0.

## Structure
- Package `demux16_pkg`: `WIDTH`, `SEL_W`, `FULL_MASK` (16'hFFFF), and the state typedef `{FILL, FULL}`.
- Sub-module `dec4to16`: combinational one-hot decoder producing the write strobe from `sel` or `ptr`.

## Test plan
- Sequential word:
  - Stimulus: `mode`=1; 16 consecutive accepts of 16'h3F0A bits, LSB first; `out_ready`=1.
  - Required: `out_valid` rises the cycle after the 16th accept, with `out`=16'h3F0A and `out_mask`=16'hFFFF.
  - Then: an immediate second word is accepted with no bubble.
- Addressed word:
  - Stimulus: `mode`=0; write `sel`=15 down to 0 with bits of 16'h3F0A.
  - Required: `out`=16'h3F0A, `out_mask`=16'hFFFF.
- Partial commit:
  - Stimulus: addressed `sel`=6 `in`=1, then `sel`=12 `in`=1 with `commit`=1.
  - Required: `out`=16'h1040, `out_mask`=16'h1040.
- Overwrite:
  - Stimulus: `sel`=3 `in`=1, then `sel`=3 `in`=0 with `commit`=1.
  - Required: `out`=16'h0000, `out_mask`=16'h0008.
- Backpressure:
  - Stimulus: `out_ready`=0; complete two words (16'h3F0A, 16'h00FF).
  - Required: the second word leaves `in_ready`=0 and `out` stays 16'h3F0A.
  - Then: pulse `out_ready` for one cycle. Required: `out`=16'h00FF with `out_valid`=1, and `in_ready`=1 the next cycle.
- Reset mid-word:
  - Stimulus: 7 sequential accepts, then `rst` pulse.
  - Required: all outputs 0 and `in_ready`=1.
  - Then: the next 16 accepts produce exactly those bits (`ptr` restarted at 0).

Source files
------------

// File: rtl/demux16_pkg.sv
// -----------------------------------------------------------------------------
// demux16_pkg
// Shared constants and types for the 1-to-16 bit collector.
//   WIDTH     : assembled word width (fixed at 16)
//   SEL_W     : position select width, log2(WIDTH)
//   FULL_MASK : mask value meaning every position has been written
//   state_t   : collector state, FILL (accepting bits) / FULL (word parked)
// -----------------------------------------------------------------------------
package demux16_pkg;

   localparam int WIDTH = 16;
   localparam int SEL_W = 4;

   localparam logic [WIDTH-1:0] FULL_MASK = 16'hFFFF;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

endpackage : demux16_pkg

// File: rtl/demux16_collect_dec4to16.sv
// -----------------------------------------------------------------------------
// dec4to16
// Combinational one-hot decoder: turns a 4-bit position into the write strobe
// used to update one bit of the assembly word and its mask.
//   idx    in  SEL_W  position to write
//   strobe out WIDTH  one-hot strobe, bit idx set
// -----------------------------------------------------------------------------
module dec4to16
   import demux16_pkg::*;
(
   input  logic [SEL_W-1:0] idx,
   output logic [WIDTH-1:0] strobe
);

   assign strobe = {{(WIDTH-1){1'b0}}, 1'b1} << idx;

endmodule : dec4to16

// File: rtl/demux16_collect.sv
// -----------------------------------------------------------------------------
// demux16_collect
// Registered 1-to-16 demultiplexer/collector. Single bits arrive through a
// valid/ready handshake and are steered into an assembly word either by an
// explicit select (addressed mode) or by an auto-incrementing pointer
// (sequential mode). Completed words move to a one-entry output register.
//   clk       in   1   clock, rising edge
//   rst       in   1   asynchronous active-high reset
//   in        in   1   data bit
//   sel       in   4   target position in addressed mode
//   mode      in   1   0 = addressed, 1 = sequential
//   commit    in   1   complete the word with this accepted bit
//   in_valid  in   1   input fields valid
//   in_ready  out  1   collector can accept a bit
//   out       out  16  completed word
//   out_mask  out  16  positions written in out
//   out_valid out  1   out/out_mask valid
//   out_ready in   1   consumer takes the word
// -----------------------------------------------------------------------------
module demux16_collect
   import demux16_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in,
   input  logic [SEL_W-1:0] sel,
   input  logic             mode,
   input  logic             commit,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_mask,
   output logic             out_valid,
   input  logic             out_ready
);

   state_t           state_q,     state_d;
   logic [WIDTH-1:0] asm_q,       asm_d;
   logic [WIDTH-1:0] mask_q,      mask_d;
   logic [SEL_W-1:0] ptr_q,       ptr_d;
   logic             word_mode_q, word_mode_d;
   logic [WIDTH-1:0] out_d,       out_mask_d;
   logic             out_valid_d;

   logic             accept;
   logic             slot_free;
   logic             eff_mode;
   logic [SEL_W-1:0] wr_idx;
   logic [WIDTH-1:0] strobe;
   logic [WIDTH-1:0] asm_upd;
   logic [WIDTH-1:0] mask_upd;
   logic             done;

   // in_ready depends on state only, so it cannot form a loop with the source.
   assign in_ready  = (state_q == FILL);
   assign accept    = in_valid & in_ready;
   // Slot can take a new word if empty or being drained this cycle.
   assign slot_free = ~out_valid | out_ready;

   // The mode is sampled on the first bit of a word (empty mask) and held
   // for the rest of it.
   assign eff_mode  = (mask_q == '0) ? mode : word_mode_q;
   assign wr_idx    = eff_mode ? ptr_q : sel;

   dec4to16 u_dec (
      .idx    (wr_idx),
      .strobe (strobe)
   );

   assign asm_upd  = in ? (asm_q | strobe) : (asm_q & ~strobe);
   assign mask_upd = mask_q | strobe;
   assign done     = accept & ((mask_upd == FULL_MASK)
                               | (eff_mode & (ptr_q == SEL_W'(WIDTH-1)))
                               | commit);

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      asm_d       = asm_q;
      mask_d      = mask_q;
      ptr_d       = ptr_q;
      word_mode_d = word_mode_q;
      out_d       = out;
      out_mask_d  = out_mask;
      // A transfer empties the slot unless a new word lands in it below.
      out_valid_d = out_valid & ~out_ready;

      unique case (state_q)
         FILL: begin
            if (accept) begin
               word_mode_d = eff_mode;
               if (done && slot_free) begin
                  out_d       = asm_upd;
                  out_mask_d  = mask_upd;
                  out_valid_d = 1'b1;
                  asm_d       = '0;
                  mask_d      = '0;
                  ptr_d       = '0;
               end else if (done) begin
                  // Slot still occupied: park the finished word.
                  asm_d   = asm_upd;
                  mask_d  = mask_upd;
                  state_d = FULL;
               end else begin
                  asm_d  = asm_upd;
                  mask_d = mask_upd;
                  if (eff_mode) ptr_d = ptr_q + SEL_W'(1);
               end
            end
         end
         FULL: begin
            if (slot_free) begin
               out_d       = asm_q;
               out_mask_d  = mask_q;
               out_valid_d = 1'b1;
               asm_d       = '0;
               mask_d      = '0;
               ptr_d       = '0;
               state_d     = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FILL;
         asm_q       <= '0;
         mask_q      <= '0;
         ptr_q       <= '0;
         word_mode_q <= 1'b0;
         out         <= '0;
         out_mask    <= '0;
         out_valid   <= 1'b0;
      end else begin
         state_q     <= state_d;
         asm_q       <= asm_d;
         mask_q      <= mask_d;
         ptr_q       <= ptr_d;
         word_mode_q <= word_mode_d;
         out         <= out_d;
         out_mask    <= out_mask_d;
         out_valid   <= out_valid_d;
      end
   end

endmodule : demux16_collect

// File: tb/tb_demux16_collect.sv
// -----------------------------------------------------------------------------
// tb_demux16_collect
// Self-checking bench for demux16_collect: a table of word-level vectors plus
// hand-written sequences for mode latching, overwrite, backpressure and reset.
// Expected words go into a scoreboard queue when stimulus is driven and are
// compared when the DUT hands the word over (out_valid & out_ready).
// -----------------------------------------------------------------------------
module tb_demux16_collect;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in = 1'b0;
   logic [3:0]  sel = '0;
   logic        mode = 1'b0;
   logic        commit = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] out;
   logic [15:0] out_mask;
   logic        out_valid;
   logic        out_ready = 1'b1;

   always #5 clk = ~clk;

   demux16_collect dut (
      .clk       (clk),
      .rst       (rst),
      .in        (in),
      .sel       (sel),
      .mode      (mode),
      .commit    (commit),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out       (out),
      .out_mask  (out_mask),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   typedef struct {
      logic        mode;
      logic [15:0] wr;          // positions written (ascending seq / descending addressed)
      logic [15:0] data;
      logic        commit_last;
      logic [15:0] exp_out;
      logic [15:0] exp_mask;
   } vec_t;

   typedef struct {
      logic [15:0] word;
      logic [15:0] mask;
   } exp_t;

   vec_t vecs[7];
   exp_t sb[$];
   int   tests  = 0;
   int   fails  = 0;
   int   stalls = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard side: a word leaves the DUT on the edge after this negedge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_word", out, 16'hxxxx);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_out", out, e.word);
            check("sb_mask", out_mask, e.mask);
         end
      end
   end

   // Drive one bit; returns 1 ns after the accepting edge with in_valid low.
   task automatic send(input logic b, input logic [3:0] s, input logic m, input logic c);
      int waited = 0;
      in = b; sel = s; mode = m; commit = c; in_valid = 1'b1;
      while (!in_ready && waited < 64) begin
         @(posedge clk); #1;
         waited++;
      end
      stalls += waited;
      if (!in_ready) begin
         check("send_timeout_in_ready", 16'(in_ready), 16'h0001);
      end else begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0; commit = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      int k = 0;
      n = $countones(v.wr);
      sb.push_back('{word: v.exp_out, mask: v.exp_mask});
      if (v.mode) begin
         for (int i = 0; i < 16; i++) if (v.wr[i]) begin
            k++;
            // sel carries junk to show it is ignored in sequential mode
            send(v.data[i], 4'(15 - i), 1'b1, v.commit_last && (k == n));
         end
      end else begin
         for (int i = 15; i >= 0; i--) if (v.wr[i]) begin
            k++;
            send(v.data[i], 4'(i), 1'b0, v.commit_last && (k == n));
         end
      end
   endtask

   task automatic send_seq_word(input logic [15:0] d);
      sb.push_back('{word: d, mask: 16'hFFFF});
      for (int i = 0; i < 16; i++) send(d[i], 4'(i), 1'b1, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      vecs[0] = '{1'b1, 16'hFFFF, 16'h3F0A, 1'b0, 16'h3F0A, 16'hFFFF};
      vecs[1] = '{1'b1, 16'hFFFF, 16'hA5C3, 1'b0, 16'hA5C3, 16'hFFFF};
      vecs[2] = '{1'b0, 16'hFFFF, 16'h3F0A, 1'b0, 16'h3F0A, 16'hFFFF};
      vecs[3] = '{1'b0, 16'h1040, 16'h1040, 1'b1, 16'h1040, 16'h1040};
      vecs[4] = '{1'b0, 16'h00F0, 16'h0050, 1'b1, 16'h0050, 16'h00F0};
      vecs[5] = '{1'b1, 16'h001F, 16'h0015, 1'b1, 16'h0015, 16'h001F};
      vecs[6] = '{1'b1, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 16'hFFFF};

      // Reset state
      #12;
      check("rst_out", out, 16'h0000);
      check("rst_mask", out_mask, 16'h0000);
      check("rst_valid", 16'(out_valid), 16'h0000);
      check("rst_in_ready", 16'(in_ready), 16'h0001);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Table-driven words, slot always drained
      for (int v = 0; v < 7; v++) begin
         run_vec(vecs[v]);
         check($sformatf("vec%0d_valid_after_last", v), 16'(out_valid), 16'h0001);
         if (v == 1) check("no_bubble_two_seq_words", 16'(stalls), 16'h0000);
      end
      idle(2);

      // Mode latched on the first bit: later mode=0 and sel values are ignored
      sb.push_back('{word: 16'hC3A5, mask: 16'hFFFF});
      for (int i = 0; i < 16; i++) begin
         logic [15:0] d;
         d = 16'hC3A5;
         send(d[i], 4'(i * 7), (i == 0), 1'b0);
      end
      idle(2);

      // Overwrite of one position
      sb.push_back('{word: 16'h0000, mask: 16'h0008});
      send(1'b1, 4'd3, 1'b0, 1'b0);
      send(1'b0, 4'd3, 1'b0, 1'b1);
      idle(2);

      // Backpressure: two words with the slot held
      out_ready = 1'b0;
      send_seq_word(16'h3F0A);
      send_seq_word(16'h00FF);
      check("bp_in_ready_low", 16'(in_ready), 16'h0000);
      check("bp_out_held", out, 16'h3F0A);
      idle(3);
      check("bp_out_stable", out, 16'h3F0A);
      check("bp_valid_held", 16'(out_valid), 16'h0001);
      check("bp_still_full", 16'(in_ready), 16'h0000);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_second_out", out, 16'h00FF);
      check("bp_second_valid", 16'(out_valid), 16'h0001);
      check("bp_in_ready_back", 16'(in_ready), 16'h0001);
      idle(2);
      out_ready = 1'b1;
      idle(3);

      // Reset mid-word
      for (int i = 0; i < 7; i++) send(1'b1, 4'd0, 1'b1, 1'b0);
      rst = 1'b1;
      #3;
      check("mid_rst_out", out, 16'h0000);
      check("mid_rst_mask", out_mask, 16'h0000);
      check("mid_rst_valid", 16'(out_valid), 16'h0000);
      check("mid_rst_in_ready", 16'(in_ready), 16'h0001);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      run_vec(vecs[0]);
      idle(2);

      // Drain: every expected word must have come out
      for (int i = 0; i < 100 && sb.size() != 0; i++) idle(1);
      check("scoreboard_empty", 16'(sb.size()), 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_demux16_collect
